// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction stage FSM with memory handshakes, timeout traps,
// halt handling and cycle/retired-instruction counters.
module stage_sequencer #(
    parameter int CNT_W       = 64,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic [2:0]       stage,
    output logic             fetch_req,
    output logic             mem_req,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEMORY  = 3'd3,
        S_REG_UPD = 3'd4,
        S_PC_UPD  = 3'd5,
        S_HALT    = 3'd6,
        S_TRAP    = 3'd7
    } stage_e;

    stage_e              stage_q, stage_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          cause_q, cause_d;
    logic                boot_q;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    instret_q, instret_d;
    logic                is_mem, is_legal, halt_at_boot;

    assign is_mem   = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign is_legal = is_mem || (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LUI) ||
                      (opcode == OPC_AUIPC) || (opcode == OPC_JAL) || (opcode == OPC_JALR) ||
                      (opcode == OPC_BRANCH);
    // The first cycle after reset stands in for the entry into FETCH, so halt_req is honoured there too.
    assign halt_at_boot = boot_q && halt_req;

    always_comb begin
        stage_d = stage_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        case (stage_q)
            S_FETCH: begin
                if (halt_at_boot) stage_d = S_HALT;
                else if (imem_ready) stage_d = S_DECODE;
                else if (wait_q == WAIT_LIMIT) begin
                    stage_d = S_TRAP;
                    cause_d = 2'd2;
                end else wait_d = wait_q + 1'b1;
            end
            S_DECODE: begin
                stage_d = is_legal ? S_EXECUTE : S_TRAP;
                cause_d = is_legal ? cause_q : 2'd1;
            end
            S_EXECUTE: begin
                stage_d = is_mem ? S_MEMORY : S_REG_UPD;
                wait_d  = '0;
            end
            S_MEMORY: begin
                if (dmem_ready) stage_d = S_REG_UPD;
                else if (wait_q == WAIT_LIMIT) begin
                    stage_d = S_TRAP;
                    cause_d = 2'd3;
                end else wait_d = wait_q + 1'b1;
            end
            S_REG_UPD: stage_d = S_PC_UPD;
            S_PC_UPD: begin
                stage_d = halt_req ? S_HALT : S_FETCH;
                wait_d  = '0;
            end
            S_HALT: begin
                stage_d = halt_req ? S_HALT : S_FETCH;
                wait_d  = '0;
            end
            S_TRAP: stage_d = S_TRAP;
        endcase
    end

    assign halted    = (stage_q == S_HALT) || (stage_q == S_TRAP);
    assign cycle_d   = halted ? cycle_q : cycle_q + 1'b1;
    assign instret_d = (stage_q == S_PC_UPD) ? instret_q + 1'b1 : instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q   <= S_FETCH;
            wait_q    <= '0;
            cause_q   <= 2'd0;
            boot_q    <= 1'b1;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            stage_q   <= stage_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            boot_q    <= 1'b0;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign stage       = stage_q;
    assign fetch_req   = (stage_q == S_FETCH) && !halt_at_boot;
    assign mem_req     = (stage_q == S_MEMORY);
    assign trap        = (stage_q == S_TRAP);
    assign trap_cause  = cause_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: table-driven and hand-sequenced checks of the stage sequencer
// with 4-bit counters and a timeout of 3 wait cycles.
module tb_stage_sequencer;
    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ILL = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = OP;
    logic       imem_ready = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0;
    logic [2:0] stage;
    logic       fetch_req, mem_req, halted, trap;
    logic [1:0] trap_cause;
    logic [3:0] cycle_cnt, instret_cnt;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    stage_sequencer #(.CNT_W(4), .MEM_TIMEOUT(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .halt_req(halt_req), .stage(stage), .fetch_req(fetch_req),
        .mem_req(mem_req), .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct {
        logic       r;
        logic [6:0] op;
        logic       im, dm, hr;
        logic [2:0] st;
        logic       fr, mr, hl, tr;
        logic [1:0] tc;
        logic [3:0] cy, rt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic add(input logic r, input logic [6:0] op, input logic im, input logic dm, input logic hr,
                       input logic [2:0] st, input logic fr, input logic mr, input logic hl, input logic tr,
                       input logic [1:0] tc, input logic [3:0] cy, input logic [3:0] rt);
        vec_t v;
        v = '{r, op, im, dm, hr, st, fr, mr, hl, tr, tc, cy, rt};
        tbl.push_back(v);
    endtask

    initial begin
        // reset, then one OP instruction: 0,1,2,4,5,0
        add(1'b0, OP, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
        add(1'b0, OP, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
        add(1'b1, OP, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 4'd0);
        add(1'b1, OP, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 4'd0);
        add(1'b1, OP, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 4'd0);
        add(1'b1, OP, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd4, 4'd0);
        add(1'b1, OP, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd5, 4'd1);
        // LOAD with dmem_ready low 3 cycles, high on the 4th (limit cycle, ready wins)
        add(1'b1, LD, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd6, 4'd1);
        add(1'b1, LD, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd7, 4'd1);
        add(1'b1, LD, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd8, 4'd1);
        add(1'b1, LD, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd9, 4'd1);
        add(1'b1, LD, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd10, 4'd1);
        add(1'b1, LD, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd11, 4'd1);
        add(1'b1, LD, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd12, 4'd1);
        add(1'b1, LD, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd13, 4'd1);
        add(1'b1, LD, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd14, 4'd2);
        // illegal opcode traps from DECODE; counters freeze, halt_req ignored, reset clears
        add(1'b1, ILL, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd15, 4'd2);
        add(1'b1, ILL, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd0, 4'd2);
        add(1'b1, ILL, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd0, 4'd2);
        add(1'b1, OP, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd0, 4'd2);
        add(1'b0, OP, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);

        foreach (tbl[i]) begin
            rst_n = tbl[i].r; opcode = tbl[i].op; imem_ready = tbl[i].im;
            dmem_ready = tbl[i].dm; halt_req = tbl[i].hr;
            step();
            chk($sformatf("v%0d stage", i), 64'(stage), 64'(tbl[i].st));
            chk($sformatf("v%0d fetch_req", i), 64'(fetch_req), 64'(tbl[i].fr));
            chk($sformatf("v%0d mem_req", i), 64'(mem_req), 64'(tbl[i].mr));
            chk($sformatf("v%0d halted", i), 64'(halted), 64'(tbl[i].hl));
            chk($sformatf("v%0d trap", i), 64'(trap), 64'(tbl[i].tr));
            chk($sformatf("v%0d trap_cause", i), 64'(trap_cause), 64'(tbl[i].tc));
            chk($sformatf("v%0d cycle_cnt", i), 64'(cycle_cnt), 64'(tbl[i].cy));
            chk($sformatf("v%0d instret_cnt", i), 64'(instret_cnt), 64'(tbl[i].rt));
        end

        // imem timeout: 4 waiting FETCH cycles then TRAP cause 2
        rst_n = 1'b1; opcode = OP; imem_ready = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
        run(3);
        chk("itmo stage before limit", 64'(stage), 64'd0);
        chk("itmo fetch_req before limit", 64'(fetch_req), 64'd1);
        step();
        chk("itmo stage", 64'(stage), 64'd7);
        chk("itmo trap", 64'(trap), 64'd1);
        chk("itmo cause", 64'(trap_cause), 64'd2);
        chk("itmo cycle_cnt", 64'(cycle_cnt), 64'd4);
        rst_n = 1'b0;
        step();
        chk("itmo reset trap", 64'(trap), 64'd0);
        chk("itmo reset cause", 64'(trap_cause), 64'd0);

        // imem ready on the limit cycle wins over the timeout
        rst_n = 1'b1;
        run(3);
        imem_ready = 1'b1;
        step();
        chk("ilim stage", 64'(stage), 64'd1);
        chk("ilim trap", 64'(trap), 64'd0);
        chk("ilim cycle_cnt", 64'(cycle_cnt), 64'd4);

        // halt_req raised in EXECUTE takes effect only after PC_UPDATE
        step();
        chk("halt exec stage", 64'(stage), 64'd2);
        halt_req = 1'b1;
        run(2);
        chk("halt pc stage", 64'(stage), 64'd5);
        step();
        chk("halt stage", 64'(stage), 64'd6);
        chk("halt halted", 64'(halted), 64'd1);
        chk("halt trap", 64'(trap), 64'd0);
        chk("halt fetch_req", 64'(fetch_req), 64'd0);
        chk("halt instret", 64'(instret_cnt), 64'd1);
        chk("halt cycle_cnt", 64'(cycle_cnt), 64'd8);
        step();
        chk("halt hold stage", 64'(stage), 64'd6);
        chk("halt frozen cycle_cnt", 64'(cycle_cnt), 64'd8);
        halt_req = 1'b0;
        step();
        chk("resume stage", 64'(stage), 64'd0);
        chk("resume fetch_req", 64'(fetch_req), 64'd1);
        chk("resume halted", 64'(halted), 64'd0);
        chk("resume instret", 64'(instret_cnt), 64'd1);
        chk("resume cycle_cnt", 64'(cycle_cnt), 64'd8);

        // dmem timeout: LOAD with dmem_ready never high -> TRAP cause 3
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; opcode = LD; imem_ready = 1'b1; dmem_ready = 1'b0;
        run(6);
        chk("dtmo stage before limit", 64'(stage), 64'd3);
        chk("dtmo mem_req before limit", 64'(mem_req), 64'd1);
        step();
        chk("dtmo stage", 64'(stage), 64'd7);
        chk("dtmo cause", 64'(trap_cause), 64'd3);
        chk("dtmo mem_req", 64'(mem_req), 64'd0);
        chk("dtmo halted", 64'(halted), 64'd1);

        // halt_req at reset release: go straight to HALT without a fetch request
        rst_n = 1'b0; halt_req = 1'b1; opcode = OP;
        step();
        chk("boot halt stage", 64'(stage), 64'd0);
        chk("boot halt fetch_req", 64'(fetch_req), 64'd0);
        rst_n = 1'b1;
        step();
        chk("boot halt to HALT", 64'(stage), 64'd6);
        chk("boot halt cycle_cnt", 64'(cycle_cnt), 64'd1);
        halt_req = 1'b0;
        step();
        chk("boot resume stage", 64'(stage), 64'd0);
        chk("boot resume fetch_req", 64'(fetch_req), 64'd1);

        // 16 OP instructions: 4-bit counters wrap to 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            run(5);
            chk($sformatf("wrap k%0d stage", k), 64'(stage), 64'd0);
            chk($sformatf("wrap k%0d instret", k), 64'(instret_cnt), 64'(k % 16));
            chk($sformatf("wrap k%0d cycle_cnt", k), 64'(cycle_cnt), 64'((5 * k) % 16));
        end

        // STORE with both readys held: 6 cycles
        opcode = ST; dmem_ready = 1'b1;
        run(3);
        chk("store mem stage", 64'(stage), 64'd3);
        chk("store mem_req", 64'(mem_req), 64'd1);
        run(3);
        chk("store done stage", 64'(stage), 64'd0);
        chk("store instret", 64'(instret_cnt), 64'd1);
        chk("store cycle_cnt", 64'(cycle_cnt), 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
